// File: rtl/seq_match_ctrl.sv
// -----------------------------------------------------------------------------
// seq_match_ctrl
//
// Word-level controller around a 3-bit serial pattern recognizer. A WIDTH-bit
// word is accepted on the input handshake, scanned MSB-first one bit per clock
// against a 3-bit pattern, and the per-word match count is returned on the
// output handshake. A saturating 16-bit running total of matches is kept.
//
// Build option:
//   OVERLAP_EN  defined   -> overlapping detection (history continues after a
//                            match, so 01010 / pattern 010 gives 2)
//               undefined -> non-overlapping detection (a match restarts the
//                            three-bit window, so 01010 / pattern 010 gives 1)
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_in_valid   producer has a word
//   o_in_ready   controller can accept a word (state == IDLE)
//   i_in_data    word to scan, bit WIDTH-1 scanned first
//   i_pattern    pattern to match, bit 2 is the oldest bit; sampled with data
//   o_out_valid  per-word result available (state == DONE)
//   i_out_ready  consumer takes result
//   o_out_count  matches found in the last word
//   o_y          one-cycle registered match pulse
//   o_busy       high in SHIFT or DONE
//   o_total      saturating match total since reset
//   o_state      current FSM state (0 IDLE, 1 SHIFT, 2 DONE) for observation
//
// Handshake semantics (both ports): a transfer happens on a rising clock edge
// where valid and ready are both 1. Ready/valid are pure state decodes, so
// there is no combinational path from a peer's valid to our ready. Once
// o_out_valid is raised, o_out_count holds stable until the transfer.
// -----------------------------------------------------------------------------
module seq_match_ctrl #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic [2:0]       i_pattern,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [CW-1:0]    o_out_count,
    output logic             o_y,
    output logic             o_busy,
    output logic [15:0]      o_total,
    output logic [1:0]       o_state
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_data;
    logic [2:0]       r_pat;
    logic [1:0]       r_hist;
    logic [1:0]       r_hv;     // number of valid history bits, saturates at 3
    logic [IW-1:0]    r_idx;
    logic [CW-1:0]    r_count;
    logic             r_y;
    logic [15:0]      r_total;

    logic             w_bit;
    logic [2:0]       w_win;
    logic             w_match;
    logic [1:0]       w_hv_inc;
    logic [1:0]       w_hv_next;

    always_comb begin
        w_bit    = r_data[r_idx];
        w_win    = {r_hist, w_bit};
        // A window is only meaningful once two earlier bits of this word exist.
        w_match  = (r_hv >= 2'd2) && (w_win == r_pat);
        w_hv_inc = (r_hv == 2'd3) ? 2'd3 : r_hv + 2'd1;
`ifdef OVERLAP_EN
        w_hv_next = w_hv_inc;
`else
        // Non-overlapping: a match consumes its three bits.
        w_hv_next = w_match ? 2'd0 : w_hv_inc;
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_pat   <= '0;
            r_hist  <= '0;
            r_hv    <= '0;
            r_idx   <= '0;
            r_count <= '0;
            r_y     <= 1'b0;
            r_total <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_y <= 1'b0;
                    if (i_in_valid) begin
                        r_data  <= i_in_data;
                        r_pat   <= i_pattern;
                        r_count <= '0;
                        r_hist  <= '0;
                        r_hv    <= '0;
                        r_idx   <= IW'(WIDTH - 1);
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_hist <= w_win[1:0];
                    r_hv   <= w_hv_next;
                    r_y    <= w_match;
                    if (w_match) begin
                        r_count <= r_count + CW'(1);
                        if (r_total != 16'hFFFF) begin
                            r_total <= r_total + 16'd1;
                        end
                    end
                    if (r_idx == '0) begin
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx - IW'(1);
                    end
                end
                DONE: begin
                    r_y <= 1'b0;
                    if (i_out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_y     <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_in_ready  = (r_state == IDLE);
    assign o_out_valid = (r_state == DONE);
    assign o_busy      = (r_state != IDLE);
    assign o_out_count = r_count;
    assign o_y         = r_y;
    assign o_total     = r_total;
    assign o_state     = r_state;

endmodule

// File: tb/tb_seq_match_ctrl.sv
module tb_seq_match_ctrl;

    localparam int WIDTH = 8;
    localparam int CW    = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [2:0]       pattern;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    out_count;
    logic             y;
    logic             busy;
    logic [15:0]      total;
    logic [1:0]       state;

    int n_checks;
    int n_errors;
    logic [15:0] exp_total;

    seq_match_ctrl #(.WIDTH(WIDTH), .CW(CW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (in_data),
        .i_pattern   (pattern),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_count (out_count),
        .o_y         (y),
        .o_busy      (busy),
        .o_total     (total),
        .o_state     (state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scan one word from IDLE: accept, WIDTH bit edges (y checked after each),
    // then result check and release.
    task automatic run_word(input logic [2:0] pat, input logic [7:0] data,
                            input logic [3:0] exp_cnt, input logic [7:0] ymask);
        check("pre_in_ready", {31'd0, in_ready}, 32'd1);
        pattern  = pat;
        in_data  = data;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("acc_busy", {31'd0, busy}, 32'd1);
        check("acc_in_ready", {31'd0, in_ready}, 32'd0);
        for (int k = 0; k < WIDTH; k++) begin
            tick();
            check($sformatf("y_edge%0d", k + 1), {31'd0, y}, {31'd0, ymask[k]});
        end
        exp_total = exp_total + 16'(exp_cnt);
        check("done_out_valid", {31'd0, out_valid}, 32'd1);
        check("done_out_count", {28'd0, out_count}, {28'd0, exp_cnt});
        check("done_total", {16'd0, total}, {16'd0, exp_total});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);
        check("rel_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0] pat;
        logic [7:0] data;
        logic [3:0] cnt;
        logic [7:0] ymask;  // bit k-1 = y expected high after bit edge k
    } vec_t;

    vec_t vecs[5];

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        exp_total = 16'd0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        pattern   = '0;
        out_ready = 1'b0;

`ifdef OVERLAP_EN
        vecs[0] = '{3'b010, 8'b01010010, 4'd3, 8'b1001_0100};
        vecs[1] = '{3'b101, 8'hAA,       4'd3, 8'b0101_0100};
        vecs[2] = '{3'b111, 8'h00,       4'd0, 8'b0000_0000};
        vecs[3] = '{3'b111, 8'hFF,       4'd6, 8'b1111_1100};
        vecs[4] = '{3'b111, 8'hFF,       4'd6, 8'b1111_1100};
`else
        vecs[0] = '{3'b010, 8'b01010010, 4'd2, 8'b1000_0100};
        vecs[1] = '{3'b101, 8'hAA,       4'd2, 8'b0100_0100};
        vecs[2] = '{3'b111, 8'h00,       4'd0, 8'b0000_0000};
        vecs[3] = '{3'b111, 8'hFF,       4'd2, 8'b0010_0100};
        vecs[4] = '{3'b111, 8'hFF,       4'd2, 8'b0010_0100};
`endif

        // ---- reset values ----
        tick();
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_count", {28'd0, out_count}, 32'd0);
        check("rst_y", {31'd0, y}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_total", {16'd0, total}, 32'd0);
        check("rst_state", {30'd0, state}, {30'd0, ST_IDLE});
        rst_n = 1'b1;
        tick();

        // ---- table vectors (last two are back-to-back 0xFF words) ----
        for (int v = 0; v < 5; v++) begin
            run_word(vecs[v].pat, vecs[v].data, vecs[v].cnt, vecs[v].ymask);
        end

        // ---- result backpressure ----
        pattern  = 3'b101;
        in_data  = 8'hAA;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < WIDTH; k++) tick();
        exp_total = exp_total + 16'(vecs[1].cnt);
        in_valid  = 1'b1;
        in_data   = 8'hFF;
        pattern   = 3'b111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_out_count", {28'd0, out_count}, {28'd0, vecs[1].cnt});
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_state", {30'd0, state}, {30'd0, ST_DONE});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_rel_in_ready", {31'd0, in_ready}, 32'd1);
        check("bp_rel_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        in_valid = 1'b0;
        check("bp_next_acc_state", {30'd0, state}, {30'd0, ST_SHIFT});
        for (int k = 0; k < WIDTH; k++) tick();
        exp_total = exp_total + 16'(vecs[3].cnt);
        check("bp_next_count", {28'd0, out_count}, {28'd0, vecs[3].cnt});
        check("bp_next_total", {16'd0, total}, {16'd0, exp_total});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // ---- asynchronous reset mid-SHIFT ----
        pattern  = 3'b101;
        in_data  = 8'hAA;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        exp_total = 16'd0;
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_out_count", {28'd0, out_count}, 32'd0);
        check("arst_y", {31'd0, y}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_total", {16'd0, total}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_word(vecs[0].pat, vecs[0].data, vecs[0].cnt, vecs[0].ymask);

        // ---- pattern change during SHIFT: only 010 may count ----
        // 01011110 holds one 010 (edge 3) and two 111 windows (edges 6,7).
        pattern  = 3'b010;
        in_data  = 8'b01011110;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        pattern = 3'b111;
        for (int k = 1; k < WIDTH; k++) tick();
        exp_total = exp_total + 16'd1;
        check("pchg_out_valid", {31'd0, out_valid}, 32'd1);
        check("pchg_count", {28'd0, out_count}, 32'd1);
        check("pchg_total", {16'd0, total}, {16'd0, exp_total});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pchg_idle", {30'd0, state}, {30'd0, ST_IDLE});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_match_ctrl.md
# seq_match_ctrl

Word-level controller that sequences a serial 3-bit pattern detector over parallel input words. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it MSB-first through a programmable 3-bit pattern recognizer, one bit per clock. It then returns the per-word match count through a second valid/ready handshake. It sits between a word producer and the match-statistics logic, replacing hand-driven bit-serial stimulus of the FSM recognizers (010/101 class).

## Interface
- WIDTH, 8, bits per input word (≥3)
- CW, $clog2(WIDTH+1), width of per-word match count
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  producer has a word
- in_ready  output  1  controller can accept a word
- in_data  input  WIDTH  word to scan, bit WIDTH-1 scanned first
- pattern  input  3  pattern to match, pattern[2] oldest bit; sampled with in_data
- out_valid  output  1  per-word result available
- out_ready  input  1  consumer takes result
- out_count  output  CW  matches found in last word
- y  output  1  one-cycle match pulse
- busy  output  1  high in SHIFT or DONE
- total  output  16  saturating match total since reset

## Operation
- States: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - When in_valid=1 at an edge: latch in_data and pattern, clear count, hist=0, hv=0, idx=WIDTH-1, go to SHIFT.
- SHIFT: each edge processes bit b=data[idx].
  - Candidate window w={hist[1:0],b}.
  - match = (hv≥2) && (w==pat).
  - hist<=w; hv<=min(hv+1,3).
  - On match: count<=count+1, y<=1 next cycle, total<=total+1 unless total=16'hFFFF.
  - When idx=0 at the edge: go to DONE; otherwise idx<=idx-1.
- DONE:
  - out_valid=1, out_count=count, held stable.
  - When out_ready=1 at an edge: go to IDLE.
  - in_valid is ignored (in_ready=0).
- History never spans words; hist and hv are cleared on every accept.
- pattern changes outside the accept edge have no effect on the word in progress.
- count cannot overflow: there are at most WIDTH-2 matches and CW holds WIDTH.

## Timing
- Reset values: in_ready=1, out_valid=0, out_count=0, y=0, busy=0, total=0. Internal hist, hv, idx and count are 0.
- Reset is asynchronous. Asserting it mid-SHIFT or in DONE returns to IDLE immediately and discards the word and its result. total is also cleared.
- Word accepted at edge 0. Bits are processed at edges 1..WIDTH. out_valid rises after edge WIDTH. Minimum accept-to-accept spacing is WIDTH+2 cycles with out_ready held high.
- y is registered: it is high during the cycle following the edge that processed the completing bit. Consecutive matches give consecutive y pulses.
- out_count and total update at the same edge as the match.
- Backpressure: DONE persists indefinitely while out_ready=0. in_ready stays low throughout SHIFT and DONE.
- in_ready is a pure state decode (IDLE), with no combinational path from in_valid. out_valid is a decode of DONE.

## Configuration
- Macro OVERLAP_EN.
  - Defined: overlapping detection. hv and hist continue after a match, so 01010 with pattern 010 gives 2.
  - Undefined: non-overlapping detection. On a match, hv<=0 regardless of the normal increment, so the next match needs three fresh bits. 01010 with pattern 010 gives 1.
- Everything else is identical in both builds.

## Test plan
- Reset, then pattern=3'b010, in_data=8'b01010010 -> out_valid after 9 cycles, out_count=3 (OVERLAP_EN) / 2 (no macro); y pulses after bit edges 3,5,8 / 3,8; total=3 / 2.
- pattern=3'b101, in_data=8'hAA -> out_count=3 (OVERLAP_EN) / 2; pattern=3'b111, in_data=8'h00 -> out_count=0, y never high.
- Result backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> out_valid and out_count stable, in_ready=0, second word not accepted; release -> IDLE, then word accepted next edge.
- Reset asserted at bit edge 4 of in_data=8'hAA -> all outputs at reset values immediately, total=0; next word scans cleanly from IDLE.
- Back-to-back: two words 8'hFF with pattern 3'b111 and out_ready=1 -> counts 6,6 (OVERLAP_EN) / 2,2; total=12 / 4; no history carried between words.
- Pattern change mid-word: accept with pattern=3'b010, change pattern to 3'b111 during SHIFT -> count matches 010 only.
